// File: rtl/vc_td_deq_sched_pkg.sv
// Shared definitions for the two-domain time-division dequeue scheduler:
// domain count, domain ID width and the domain identifiers.
package vc_td_deq_sched_pkg;

    localparam int VC_TD_NUM_DOMAINS = 2;
    localparam int VC_TD_SD_NBITS    = 1;

    typedef enum logic [VC_TD_SD_NBITS-1:0] {
        VC_TD_SD0 = 1'b0,
        VC_TD_SD1 = 1'b1
    } sd_e;

    function automatic sd_e other_sd(input sd_e sd);
        return (sd == VC_TD_SD0) ? VC_TD_SD1 : VC_TD_SD0;
    endfunction

endpackage

// File: rtl/vc_td_deq_sched_if.sv
// Bundle of the two per-domain dequeue ports, the merged output port and
// the slot-owner tag. master = scheduler side, slave = queues/consumer side.
interface vc_td_deq_sched_if #(
    parameter int p_msg_nbits = 32
);

    // Every port is val/rdy: a transfer happens on a clk edge where both val
    // and rdy are 1; val may not depend on rdy, rdy may depend on val.
    logic                   in0_val;
    logic                   in0_rdy;
    logic [p_msg_nbits-1:0] in0_msg;
    logic                   in1_val;
    logic                   in1_rdy;
    logic [p_msg_nbits-1:0] in1_msg;
    logic                   out_val;
    logic                   out_rdy;
    logic [p_msg_nbits-1:0] out_msg;
    logic                   out_sd;
    logic                   cur_sd;

    modport master (
        input  in0_val, in0_msg, in1_val, in1_msg, out_rdy,
        output in0_rdy, in1_rdy, out_val, out_msg, out_sd, cur_sd
    );

    modport slave (
        output in0_val, in0_msg, in1_val, in1_msg, out_rdy,
        input  in0_rdy, in1_rdy, out_val, out_msg, out_sd, cur_sd
    );

endinterface

// File: rtl/vc_td_slot_timer.sv
// Free-running slot timer: fixed-length slots alternating between SD0 and
// SD1, with an acceptance window that closes p_dead_cycles before slot end.
module vc_td_slot_timer
    import vc_td_deq_sched_pkg::*;
#(
    parameter int  p_slot_cycles = 16,
    parameter int  p_dead_cycles = 2,
    localparam int c_cnt_nbits   = $clog2(p_slot_cycles)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [c_cnt_nbits-1:0] cnt_o,
    output sd_e                    cur_sd_o,
    output logic                   win_o
);

    localparam int unsigned c_last    = p_slot_cycles - 1;
    localparam int unsigned c_win_end = p_slot_cycles - p_dead_cycles;

    logic [c_cnt_nbits-1:0] cnt_q, cnt_d;
    sd_e                    sd_q, sd_d;
    logic                   last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            sd_q  <= VC_TD_SD0;
        end else begin
            cnt_q <= cnt_d;
            sd_q  <= sd_d;
        end
    end

    // Slot length is independent of traffic: the owner flips on every wrap.
    always_comb begin
        cnt_d = cnt_q + c_cnt_nbits'(1);
        sd_d  = sd_q;
        last  = (32'(cnt_q) == c_last);
        if (last) begin
            cnt_d = '0;
            sd_d  = other_sd(sd_q);
        end
    end

    assign cnt_o    = cnt_q;
    assign cur_sd_o = sd_q;
    assign win_o    = (32'(cnt_q) < c_win_end);

endmodule

// File: rtl/vc_td_deq_sched.sv
// Time-division dequeue scheduler for SD0/SD1 with one holding register per
// domain. Define VC_TD_SCHED_ASSERT_EN to enable simulation-time protocol checks.
module vc_td_deq_sched
    import vc_td_deq_sched_pkg::*;
#(
    parameter int  p_msg_nbits   = 32,
    parameter int  p_slot_cycles = 16,
    parameter int  p_dead_cycles = 2,
    localparam int c_cnt_nbits   = $clog2(p_slot_cycles)
) (
    input  logic                   clk,
    input  logic                   reset,
    vc_td_deq_sched_if.master      bus,
    output logic [c_cnt_nbits-1:0] dbg_cnt_o,
    output logic [1:0]             dbg_full_o
);

    logic [c_cnt_nbits-1:0] cnt;
    sd_e                    cur_sd;
    logic                   win;
    logic                   sel;

    vc_td_slot_timer #(
        .p_slot_cycles (p_slot_cycles),
        .p_dead_cycles (p_dead_cycles)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .cnt_o    (cnt),
        .cur_sd_o (cur_sd),
        .win_o    (win)
    );

    assign sel = cur_sd;

    logic [VC_TD_NUM_DOMAINS-1:0] full_q, full_d;
    logic [p_msg_nbits-1:0]       hreg_q [VC_TD_NUM_DOMAINS];
    logic [p_msg_nbits-1:0]       hreg_d [VC_TD_NUM_DOMAINS];
    logic [p_msg_nbits-1:0]       in_msg [VC_TD_NUM_DOMAINS];
    logic [VC_TD_NUM_DOMAINS-1:0] own;
    logic [VC_TD_NUM_DOMAINS-1:0] in_val;
    logic [VC_TD_NUM_DOMAINS-1:0] in_rdy;
    logic [VC_TD_NUM_DOMAINS-1:0] do_in;
    logic                         do_out;

    assign own       = {sel, ~sel};
    assign in_val    = {bus.in1_val, bus.in0_val};
    assign in_msg[0] = bus.in0_msg;
    assign in_msg[1] = bus.in1_msg;

    // Pipe-style ready: a full register may accept when it drains this cycle.
    assign in_rdy = own & {2{win}} & (~full_q | {2{bus.out_rdy}});
    assign do_in  = in_val & in_rdy;
    assign do_out = bus.out_val & bus.out_rdy;

    always_comb begin
        full_d = full_q;
        hreg_d = hreg_q;
        for (int d = 0; d < VC_TD_NUM_DOMAINS; d++) begin
            if (do_in[d]) begin
                full_d[d] = 1'b1;
                hreg_d[d] = in_msg[d];
            end else if (do_out && own[d]) begin
                full_d[d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q    <= '0;
            hreg_q[0] <= '0;
            hreg_q[1] <= '0;
        end else begin
            full_q    <= full_d;
            hreg_q[0] <= hreg_d[0];
            hreg_q[1] <= hreg_d[1];
        end
    end

    assign bus.in0_rdy = in_rdy[0];
    assign bus.in1_rdy = in_rdy[1];
    assign bus.out_val = full_q[sel];
    assign bus.out_msg = hreg_q[sel];
    assign bus.out_sd  = sel;
    assign bus.cur_sd  = sel;

    assign dbg_cnt_o  = cnt;
    assign dbg_full_o = full_q;

`ifdef VC_TD_SCHED_ASSERT_EN
    always @(posedge clk) begin
        if (reset) begin
            if ($isunknown({bus.in0_val, bus.in1_val, bus.out_rdy})) begin
                $display("vc_td_deq_sched: X on in*_val/out_rdy");
                $finish;
            end
            if ((in_rdy & ~own) != '0) begin
                $display("vc_td_deq_sched: non-owner rdy asserted");
                $finish;
            end
            if ((do_in != '0) && !win) begin
                $display("vc_td_deq_sched: acceptance outside window");
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vc_td_deq_sched.sv
// Randomized scoreboard bench for vc_td_deq_sched (16-cycle slots, 2 dead cycles).
module tb_vc_td_deq_sched;

    localparam int W = 32;
    localparam int S = 16;
    localparam int D = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] dbg_cnt;
    logic [1:0] dbg_full;

    always #5 clk = ~clk;

    vc_td_deq_sched_if #(.p_msg_nbits(W)) bus ();

    vc_td_deq_sched #(
        .p_msg_nbits   (W),
        .p_slot_cycles (S),
        .p_dead_cycles (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dbg_cnt_o  (dbg_cnt),
        .dbg_full_o (dbg_full)
    );

    // Reference model: cycle index since reset release plus message count per domain.
    int         t;
    int         held [2];
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];
    bit         chk_en;
    logic       exp_rdy0, exp_rdy1, exp_val, exp_sd;
    logic [3:0] exp_cnt;
    logic [1:0] exp_full;
    int         n_chk, n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    endtask

    task automatic cycle(input bit v0, input bit v1, input bit r, input bit rst_n);
        int  owner;
        bit  win;
        @(negedge clk);
        reset       = rst_n;
        bus.in0_val = v0;
        bus.in1_val = v1;
        bus.in0_msg = $urandom;
        bus.in1_msg = $urandom;
        bus.out_rdy = r;
        if (!rst_n) begin
            chk_en = 1'b0;
            t = 0;
            held[0] = 0;
            held[1] = 0;
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            chk_en   = 1'b1;
            owner    = (t / S) % 2;
            win      = (t % S) < (S - D);
            exp_rdy0 = (owner == 0) && win && (held[0] == 0 || r);
            exp_rdy1 = (owner == 1) && win && (held[1] == 0 || r);
            exp_val  = held[owner] != 0;
            exp_sd   = (owner == 1);
            exp_cnt  = 4'(t % S);
            exp_full = {held[1] != 0, held[0] != 0};
            if (v0 && exp_rdy0) exp0_q.push_back(bus.in0_msg);
            if (v1 && exp_rdy1) exp1_q.push_back(bus.in1_msg);
            if (exp_val && r) held[owner] = held[owner] - 1;
            if (v0 && exp_rdy0) held[0] = held[0] + 1;
            if (v1 && exp_rdy1) held[1] = held[1] + 1;
            t++;
        end
    endtask

    task automatic run(input int n, input int vpct, input int rpct);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(99) < vpct, $urandom_range(99) < vpct,
                  $urandom_range(99) < rpct, 1'b1);
    endtask

    // Monitor: compares visible state each cycle and pops on every out transfer.
    initial begin
        logic [W-1:0] exp_msg;
        forever begin
            @(negedge clk);
            #2;
            if (chk_en) begin
                chk("in0_rdy", bus.in0_rdy, exp_rdy0);
                chk("in1_rdy", bus.in1_rdy, exp_rdy1);
                chk("cur_sd", bus.cur_sd, exp_sd);
                chk("out_sd", bus.out_sd, exp_sd);
                chk("out_val", bus.out_val, exp_val);
                chk("cnt", dbg_cnt, exp_cnt);
                chk("full", dbg_full, exp_full);
                if (bus.out_val && bus.out_rdy) begin
                    if (bus.out_sd ? (exp1_q.size() == 0) : (exp0_q.size() == 0)) begin
                        n_chk++;
                        $display("FAIL out_msg: got %0h with sd=%0d expected no transfer (t=%0d)",
                                 bus.out_msg, bus.out_sd, t);
                    end else begin
                        exp_msg = bus.out_sd ? exp1_q.pop_front() : exp0_q.pop_front();
                        chk("out_msg", bus.out_msg, exp_msg);
                    end
                end
            end
        end
    end

    initial begin
        bus.in0_val = 1'b0;
        bus.in1_val = 1'b0;
        bus.in0_msg = '0;
        bus.in1_msg = '0;
        bus.out_rdy = 1'b0;
        chk_en = 1'b0;
        n_chk = 0;
        n_pass = 0;
        t = 0;
        held[0] = 0;
        held[1] = 0;

        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        #1 chk("rst_out_msg", bus.out_msg, 0);

        run(40, 100, 100);
        run(50, 60, 0);
        run(200, 70, 70);

        run(34, 100, 0);
        while ((t % S) != 7) cycle(1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        #1 chk("rst2_out_msg", bus.out_msg, 0);

        run(200, 80, 90);
        run(40, 0, 100);

        @(negedge clk);
        chk_en = 1'b0;
        #5;
        chk("sd0_drained", exp0_q.size(), 0);
        chk("sd1_drained", exp1_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
